hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Sequential multiply/divide engine that owns the HI/LO register pair for the pipelined core. The combinational ALU only issues operations and reads results via mfhi/mflo. This block accepts mult/multu/div/divu/mthi/mtlo from the EX stage and computes iteratively, one bit per cycle. It returns HI/LO to the ALU result mux and raises a stall to the hazard unit when a read or new op collides with an in-flight operation.

Parameters:
W, 32, operand/HI/LO width
CNT_W, 6, iteration counter width (must hold W)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  issue op (qualified by op)
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
srcA  in  W  multiplicand / dividend / mthi-mtlo data
srcB  in  W  multiplier / divisor
flush  in  1  abort in-flight op (branch/exception squash)
rd_en  in  1  EX stage executing mfhi/mflo
rd_sel  in  1  0 = LO, 1 = HI
rd_data  out  W  combinational HI or LO per rd_sel
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO updated by mult/div
stall  out  1  hold pipeline

Behaviour:
- Reset (async, rst_n=0): state IDLE, HI=0, LO=0, counter=0, busy=0, done=0. All working registers cleared. Reset mid-operation discards the operation.
- States: IDLE -> CALC (32 iterations) -> FIX (1 cycle) -> IDLE.
- Accept: in IDLE, on the edge where start=1 and op is MULT/MULTU/DIV/DIVU, latch operands and enter CALC with count=0.
  - For signed ops, latch absolute values and record result signs (product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA).
- CALC: one radix-2 step per edge.
  - Multiply: shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the W-th step, go to FIX.
- FIX: apply sign correction, then write the registers.
  - Multiply: {HI,LO} = product.
  - Divide: LO = quotient, HI = remainder.
  - Return to IDLE; done=1 for exactly the following cycle.
- Latency: HI/LO hold new values W+1 edges after the accepting edge (33 at default). busy=1 from the accepting edge until the FIX edge inclusive.
- Divide by zero (srcB=0, signed or unsigned): LO=all ones, HI=srcA as issued. Same latency.
- Signed overflow (-2^(W-1) / -1): LO=0x80000000, HI=0.
- MTHI/MTLO: single cycle, in IDLE only. The register is written on the start edge; busy and done stay 0.
- stall = busy & (rd_en | start). A start while busy is ignored; the pipeline holds it until IDLE.
- rd_data reads the committed HI/LO only, never partial state.
- Simultaneous flush & start in IDLE: flush wins, op not accepted.
- flush in CALC/FIX: return to IDLE next edge. HI/LO keep their pre-op values and done stays 0.
- Op codes 110/111 with start: ignored, no state change.
- Unsigned ops treat operands as unsigned; signed ops use two's complement. Everything is W bits except the internal 2W accumulator.

Decomposition:
- Shared package: op encodings (OP_MULT..OP_MTLO), state encoding (ST_IDLE, ST_CALC, ST_FIX), W default.
- One natural sub-module, muldiv_datapath: accumulator, shift/add/subtract step and sign fix.
- The top holds the FSM, counter, HI/LO registers and the stall/read logic.

Test Plan:
- MULT srcA=-3 (0xFFFFFFFD), srcB=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; done pulses once; busy high 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100.
- Issue MULT, then rd_en=1 (mflo) on the next cycle -> stall=1 until the FIX edge. rd_data then shows the new LO, and stall drops the same cycle busy drops.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> rd_data with rd_sel=1/0 returns those values; busy/done never assert.
- DIV started, flush at cycle 10 -> IDLE next cycle, HI/LO unchanged, no done. Separately, rst_n pulsed mid-CALC -> HI=LO=0, busy=0 immediately (asynchronous).

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and the default operand width.
package hilo_muldiv_pkg;

  localparam int W_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

  // MULT/MULTU/DIV/DIVU all have op[2] clear; bit 1 selects divide, bit 0 unsigned.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative radix-2 datapath: shift-add multiply, restoring divide, and the
// final sign correction applied combinationally to the working accumulator.
module muldiv_datapath
  import hilo_muldiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic         is_signed,
  input  logic [W-1:0] srca,
  input  logic [W-1:0] srcb,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  logic [2*W-1:0] acc_q;
  logic [W-1:0]   opnd_q;
  logic [W-1:0]   raw_a_q;
  logic           div_q;
  logic           neg_main_q;
  logic           neg_rem_q;
  logic           div0_q;

  logic           sign_a, sign_b;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     trial, diff;
  logic           q_bit;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot, rem;

  assign sign_a = is_signed & srca[W-1];
  assign sign_b = is_signed & srcb[W-1];
  assign abs_a  = sign_a ? (~srca + 1'b1) : srca;
  assign abs_b  = sign_b ? (~srcb + 1'b1) : srcb;

  // Multiplier sits in the low half and is consumed LSB-first as the partial
  // product shifts down from the high half.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring step: remainder in the high half, dividend/quotient in the low half.
  assign trial    = {acc_q[2*W-1:W], acc_q[W-1]};
  assign diff     = trial - {1'b0, opnd_q};
  assign q_bit    = ~diff[W];
  assign div_next = {(q_bit ? diff[W-1:0] : trial[W-1:0]), acc_q[W-2:0], q_bit};

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      raw_a_q    <= '0;
      div_q      <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else if (load) begin
      acc_q      <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
      opnd_q     <= is_div ? abs_b : abs_a;
      raw_a_q    <= srca;
      div_q      <= is_div;
      neg_main_q <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
      div0_q     <= is_div & (srcb == '0);
    end else if (step) begin
      acc_q <= div_q ? div_next : mul_next;
    end
  end

  assign prod_fix = neg_main_q ? (~acc_q + 1'b1) : acc_q;
  assign quot     = acc_q[W-1:0];
  assign rem      = acc_q[2*W-1:W];

  // NOTE: outputs get defaults before the branches so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    res_hi = prod_fix[2*W-1:W];
    res_lo = prod_fix[W-1:0];
    if (div_q) begin
      if (div0_q) begin
        res_hi = raw_a_q;
        res_lo = '1;
      end else begin
        res_lo = neg_main_q ? (~quot + 1'b1) : quot;
        res_hi = neg_rem_q  ? (~rem + 1'b1)  : rem;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the pipelined core: sequences mult/div through the datapath,
// commits results, services mthi/mtlo and mfhi/mflo, and stalls on collisions.
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] srcA,
  input  logic [W-1:0] srcB,
  input  logic         flush,
  input  logic         rd_en,
  input  logic         rd_sel,
  output logic [W-1:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic         stall
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     hi_q, lo_q;
  logic             done_q;
  logic [W-1:0]     res_hi, res_lo;

  logic idle, accept, mt_wr, last_step, commit;

  assign idle      = (state_q == ST_IDLE);
  assign accept    = idle & start & ~flush & is_arith(op);
  assign mt_wr     = idle & start & ~flush & ((op == OP_MTHI) | (op == OP_MTLO));
  assign last_step = (cnt_q == CNT_W'(W-1));
  assign commit    = (state_q == ST_FIX) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: begin
        if (flush)          state_d = ST_IDLE;
        else if (last_step) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (accept)                  cnt_q <= '0;
      else if (state_q == ST_CALC) cnt_q <= cnt_q + 1'b1;
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (mt_wr) begin
        if (op == OP_MTHI) hi_q <= srcA;
        else               lo_q <= srcA;
      end
    end
  end

  muldiv_datapath #(.W(W)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      ((state_q == ST_CALC) & ~flush),
    .is_div    (op[1]),
    .is_signed (~op[0]),
    .srca      (srcA),
    .srcb      (srcB),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Reads see only committed HI/LO; an in-flight op holds the reader off via stall.
  assign rd_data = rd_sel ? hi_q : lo_q;
  assign busy    = ~idle;
  assign done    = done_q;
  assign stall   = busy & (rd_en | start);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: expected {HI,LO} pushed to a
// scoreboard at issue and compared when done pulses.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, rd_en, rd_sel;
  logic [2:0]  op;
  logic [31:0] srcA, srcB, rd_data;
  logic        busy, done, stall;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  hilo_muldiv_unit #(.W(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .srcA    (srcA),
    .srcB    (srcB),
    .flush   (flush),
    .rd_en   (rd_en),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv;
    int ai, bi;
    logic [31:0] q, r;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ai  = a;
    bi  = b;
    case (o)
      OP_MULT:  return sa * sbv;
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ai / bi;
        r = ai % bi;
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {model_hi, model_lo};
    endcase
  endfunction

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    rd_sel = 1'b1;
    #1 check({tag, "_hi"}, rd_data, exp_hi);
    rd_sel = 1'b0;
    #1 check({tag, "_lo"}, rd_data, exp_lo);
  endtask

  // Issue one arithmetic op and follow it to completion. poke >= 0 injects an
  // MTHI start that many cycles in, which must be stalled and ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit hold_rd, input int poke);
    int busy_n, stall_n;
    bit seen;
    logic [63:0] exp;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0; rd_en = hold_rd; rd_sel = 1'b0;
    busy_n = 0; stall_n = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy)  busy_n++;
      if (stall) stall_n++;
      if (i == poke) begin
        start = 1'b1; op = OP_MTHI; srcA = 32'hDEAD_BEEF;
        #1 check({tag, "_poke_stall"}, 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, busy_n, 32'd33);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (hold_rd) begin
      check({tag, "_stall_cycles"}, stall_n, 32'd33);
      check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
    end
    rd_en = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    read_hilo(tag, exp[63:32], exp[31:0]);
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_n;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; rd_en = 1'b0; rd_sel = 1'b0;
    op = '0; srcA = '0; srcB = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    read_hilo("rst", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, -1);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 1'b0, -1);
    run_op("div_by0_neg", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, -1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    run_op("mult_mflo", OP_MULT, 32'h0001_2345, 32'hFFFF_8000, 1'b1, -1);
    run_op("multu_poke", OP_MULTU, 32'h8000_0001, 32'h0000_0003, 1'b0, 7);

    // Back-to-back MTHI/MTLO.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; srcA = 32'h1234_5678;
    @(negedge clk);
    op = OP_MTLO; srcA = 32'h9ABC_DEF0;
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_done", 32'(done), 32'd0);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;
    read_hilo("mt", model_hi, model_lo);

    // flush together with start in IDLE: flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTHI; srcA = 32'hFFFF_0000;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    read_hilo("flush_start", model_hi, model_lo);

    // Reserved op code is a no-op.
    @(negedge clk);
    start = 1'b1; op = 3'b110; srcA = 32'h5555_AAAA; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("op110_busy", 32'(busy), 32'd0);
    read_hilo("op110", model_hi, model_lo);

    // Flush mid-divide: HI/LO untouched, no done.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; srcA = 32'd1000; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_n++;
      @(negedge clk);
    end
    check("flush_no_done", done_n, 32'd0);
    read_hilo("flush", model_hi, model_lo);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; srcA = 32'd12345; srcB = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst_busy", 32'(busy), 32'd0);
    read_hilo("arst", 32'h0, 32'h0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random mix.
    for (int k = 0; k < 8; k++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (k % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (k % 2 == 1) ra = -ra;
      run_op("rand", ro, ra, rb, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
